// File: rtl/calc_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : calc_dispatcher
// Brief    : Buffers calculator commands in a FIFO and issues them one at a
//            time to the core: start pulse, wait for done edge, then respond.
//            Define DISPATCH_TIMEOUT_EN to add the WAIT watchdog and rsp_err_o.
// Revision : 1.0 - initial release
// ============================================================================
module calc_dispatcher #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [WIDTH-1:0]       cmd_a_i,
  input  logic [WIDTH-1:0]       cmd_b_i,
  input  logic [1:0]             cmd_fct_i,
  output logic                   calc_start_o,
  output logic [WIDTH-1:0]       calc_a_o,
  output logic [WIDTH-1:0]       calc_b_o,
  output logic [1:0]             calc_fct_o,
  input  logic                   calc_done_i,
  input  logic [2*WIDTH-1:0]     calc_res_i,
  input  logic [2*WIDTH-1:0]     calc_rem_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [2*WIDTH-1:0]     rsp_res_o,
  output logic [2*WIDTH-1:0]     rsp_rem_o,
  output logic [1:0]             rsp_fct_o,
  output logic [$clog2(DEPTH):0] pending_o,
  output logic                   busy_o
`ifdef DISPATCH_TIMEOUT_EN
 ,output logic                   rsp_err_o
`endif
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("calc_dispatcher: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  state_t             r_state, w_state_next;
  logic [WIDTH-1:0]   r_mem_a   [DEPTH];
  logic [WIDTH-1:0]   r_mem_b   [DEPTH];
  logic [1:0]         r_mem_fct [DEPTH];
  logic [c_AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0]    r_count, w_count_next;
  logic               r_ready, r_done_q;
  logic [WIDTH-1:0]   r_op_a, r_op_b;
  logic [1:0]         r_op_fct;
  logic [2*WIDTH-1:0] r_rsp_res, r_rsp_rem;
  logic [1:0]         r_rsp_fct;
  logic               w_push, w_pop, w_done_evt, w_capture;

  assign w_push       = cmd_valid_i & r_ready;
  assign w_done_evt   = calc_done_i & ~r_done_q;
  assign w_count_next = r_count + c_CW'(w_push) - c_CW'(w_pop);

`ifdef DISPATCH_TIMEOUT_EN
  localparam int c_TW = $clog2(TIMEOUT + 1);
  logic [c_TW-1:0] r_wait_cnt;
  logic            w_timeout;
  logic            r_rsp_err;
`endif

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    calc_start_o = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
    w_timeout    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        calc_start_o = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_done_evt) begin
          w_capture    = 1'b1;
          w_state_next = S_RESP;
        end
`ifdef DISPATCH_TIMEOUT_EN
        else if (r_wait_cnt == c_TW'(TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = S_RESP;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready_i) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Storage needs no reset: only entries counted by r_count are ever read.
  always_ff @(posedge clock_i) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]   <= cmd_a_i;
      r_mem_b[r_wr_ptr]   <= cmd_b_i;
      r_mem_fct[r_wr_ptr] <= cmd_fct_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ready   <= 1'b0;
      r_done_q  <= 1'b0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_op_fct  <= '0;
      r_rsp_res <= '0;
      r_rsp_rem <= '0;
      r_rsp_fct <= '0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_ready  <= (w_count_next < c_CW'(DEPTH));
      r_done_q <= calc_done_i;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
        r_op_a   <= r_mem_a[r_rd_ptr];
        r_op_b   <= r_mem_b[r_rd_ptr];
        r_op_fct <= r_mem_fct[r_rd_ptr];
      end
      if (w_capture) begin
        r_rsp_res <= calc_res_i;
        r_rsp_rem <= calc_rem_i;
        r_rsp_fct <= r_op_fct;
      end
`ifdef DISPATCH_TIMEOUT_EN
      else if (w_timeout) begin
        r_rsp_res <= '0;
        r_rsp_rem <= '0;
        r_rsp_fct <= r_op_fct;
      end
`endif
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_wait_cnt <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_wait_cnt <= '0;
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + c_TW'(1);
      if (w_capture)      r_rsp_err <= 1'b0;
      else if (w_timeout) r_rsp_err <= 1'b1;
    end
  end
  assign rsp_err_o = r_rsp_err;
`endif

  assign cmd_ready_o = r_ready;
  assign calc_a_o    = r_op_a;
  assign calc_b_o    = r_op_b;
  assign calc_fct_o  = r_op_fct;
  assign rsp_valid_o = (r_state == S_RESP);
  assign rsp_res_o   = r_rsp_res;
  assign rsp_rem_o   = r_rsp_rem;
  assign rsp_fct_o   = r_rsp_fct;
  assign pending_o   = r_count;
  assign busy_o      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_calc_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for calc_dispatcher with a behavioural stub core.
module tb_calc_dispatcher;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int PW      = $clog2(DEPTH) + 1;

  logic               clock_i = 1'b0;
  logic               reset_i;
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [WIDTH-1:0]   cmd_a_i, cmd_b_i;
  logic [1:0]         cmd_fct_i;
  logic               calc_start_o;
  logic [WIDTH-1:0]   calc_a_o, calc_b_o;
  logic [1:0]         calc_fct_o;
  logic               calc_done_i;
  logic [2*WIDTH-1:0] calc_res_i, calc_rem_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [2*WIDTH-1:0] rsp_res_o, rsp_rem_o;
  logic [1:0]         rsp_fct_o;
  logic [PW-1:0]      pending_o;
  logic               busy_o;
`ifdef DISPATCH_TIMEOUT_EN
  logic               rsp_err_o;
`endif

  calc_dispatcher #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i), .cmd_fct_i(cmd_fct_i),
    .calc_start_o(calc_start_o), .calc_a_o(calc_a_o), .calc_b_o(calc_b_o),
    .calc_fct_o(calc_fct_o), .calc_done_i(calc_done_i),
    .calc_res_i(calc_res_i), .calc_rem_i(calc_rem_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_res_o(rsp_res_o), .rsp_rem_o(rsp_rem_o), .rsp_fct_o(rsp_fct_o),
    .pending_o(pending_o), .busy_o(busy_o)
`ifdef DISPATCH_TIMEOUT_EN
   ,.rsp_err_o(rsp_err_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic [2*WIDTH-1:0] res;
    logic [2*WIDTH-1:0] rem;
    logic [1:0]         fct;
  } rsp_t;

  rsp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Stub core arithmetic; the dispatcher only forwards it.
  function automatic rsp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [1:0] f);
    rsp_t r;
    r.res = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
    r.rem = (f == 2'b00) ? '0 : {a, b};
    r.fct = f;
    return r;
  endfunction

  // Stub core: 0 = pulse done after stub_delay, 1 = never, 2 = sticky done.
  int stub_mode  = 0;
  int stub_delay = 4;
  int n_starts   = 0;
  bit stub_kick  = 1'b0;

  initial begin : stub_core
    int              cd;
    bit              rerise;
    logic [WIDTH-1:0] s_a, s_b;
    logic [1:0]      s_f;
    rsp_t            e;
    cd = 0; rerise = 1'b0; s_a = '0; s_b = '0; s_f = '0;
    calc_done_i = 1'b0; calc_res_i = '0; calc_rem_i = '0;
    forever begin
      @(negedge clock_i);
      if (stub_mode != 2) calc_done_i = 1'b0;
      if (reset_i) begin
        cd = 0; rerise = 1'b0; stub_kick = 1'b0; calc_done_i = 1'b0;
      end else begin
        if (rerise) begin calc_done_i = 1'b1; rerise = 1'b0; end
        if (stub_kick) begin
          e = model(s_a, s_b, s_f);
          calc_res_i = e.res; calc_rem_i = e.rem; calc_done_i = 1'b1;
          stub_kick = 1'b0;
        end
        if (calc_start_o) begin
          n_starts++;
          s_a = calc_a_o; s_b = calc_b_o; s_f = calc_fct_o;
          cd = stub_delay;
        end else if (cd > 0) begin
          cd--;
          if (cd == 0 && stub_mode != 1) begin
            e = model(s_a, s_b, s_f);
            calc_res_i = e.res; calc_rem_i = e.rem;
            if (stub_mode == 2 && calc_done_i) begin
              calc_done_i = 1'b0; rerise = 1'b1;
            end else begin
              calc_done_i = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic push_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [1:0] f, output bit acc);
    cmd_a_i = a; cmd_b_i = b; cmd_fct_i = f; cmd_valid_i = 1'b1;
    acc = cmd_ready_o;
    if (acc) sb.push_back(model(a, b, f));
    @(negedge clock_i);
    cmd_valid_i = 1'b0;
  endtask

  // Waits for a response and consumes it (rsp_ready_i assumed high).
  task automatic take_rsp(input int max, output bit ok, output rsp_t got, output logic err);
    ok = 1'b0; got = '0; err = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (rsp_valid_o) begin
        ok  = 1'b1;
        got = {rsp_res_o, rsp_rem_o, rsp_fct_o};
`ifdef DISPATCH_TIMEOUT_EN
        err = rsp_err_o;
`endif
        break;
      end
      @(negedge clock_i);
    end
    if (ok) @(negedge clock_i);
  endtask

  task automatic wait_in_wait(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (busy_o && !calc_start_o && !rsp_valid_o) begin ok = 1'b1; break; end
      @(negedge clock_i);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; cmd_valid_i = 1'b0; cmd_a_i = '0; cmd_b_i = '0; cmd_fct_i = '0;
    rsp_ready_i = 1'b1;
    repeat (3) @(negedge clock_i);
    n_vec++;
    if ({cmd_ready_o, calc_start_o, calc_a_o, calc_b_o, calc_fct_o, rsp_valid_o,
         rsp_res_o, rsp_rem_o, rsp_fct_o, pending_o, busy_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, expected all zero",
               {cmd_ready_o, calc_start_o, calc_a_o, calc_b_o, calc_fct_o, rsp_valid_o,
                rsp_res_o, rsp_rem_o, rsp_fct_o, pending_o, busy_o});
    end
`ifdef DISPATCH_TIMEOUT_EN
    n_vec++;
    if (rsp_err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b, expected 0", rsp_err_o); end
`endif
    reset_i = 1'b0;
    @(negedge clock_i);
    n_vec++;
    if (cmd_ready_o !== 1'b1 || pending_o !== '0) begin
      n_err++;
      $display("FAIL post_reset_ready: got ready=%b pending=%0d, expected ready=1 pending=0",
               cmd_ready_o, pending_o);
    end
  endtask

  task automatic test_single();
    bit acc, ok; rsp_t got, exp; logic err; int s0;
    stub_mode = 0; stub_delay = 4; s0 = n_starts;
    push_cmd(8'h03, 8'h07, 2'b00, acc);
    n_vec++;
    if (calc_start_o !== 1'b0) begin n_err++; $display("FAIL single_start_early: got %b, expected 0", calc_start_o); end
    @(negedge clock_i);
    n_vec++;
    if (calc_start_o !== 1'b1 || calc_a_o !== 8'h03 || calc_b_o !== 8'h07) begin
      n_err++;
      $display("FAIL single_issue: got start=%b a=%h b=%h, expected start=1 a=03 b=07",
               calc_start_o, calc_a_o, calc_b_o);
    end
    @(negedge clock_i);
    n_vec++;
    if (calc_start_o !== 1'b0) begin n_err++; $display("FAIL single_start_width: got %b, expected 0", calc_start_o); end
    take_rsp(40, ok, got, err);
    n_vec++;
    if (!ok || sb.size() == 0) begin
      n_err++; $display("FAIL single_rsp: got no response, expected res=000a");
    end else begin
      exp = sb.pop_front();
      if (got !== exp || got.res !== 16'h000A) begin
        n_err++;
        $display("FAIL single_rsp: got res=%h rem=%h fct=%h, expected res=%h rem=%h fct=%h",
                 got.res, got.rem, got.fct, exp.res, exp.rem, exp.fct);
      end
    end
    n_vec++;
    if (busy_o !== 1'b0 || calc_a_o !== 8'h03 || calc_b_o !== 8'h07 || n_starts != s0 + 1) begin
      n_err++;
      $display("FAIL single_after: got busy=%b a=%h b=%h starts=%0d, expected busy=0 a=03 b=07 starts=1",
               busy_o, calc_a_o, calc_b_o, n_starts - s0);
    end
  endtask

  task automatic test_back_to_back();
    bit acc, ok; rsp_t got, exp; logic err; int n_acc; bit rose;
    stub_mode = 1; n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      push_cmd(WIDTH'(i * 3 + 1), WIDTH'(i + 2), 2'(i), acc);
      if (acc) n_acc++;
    end
    n_vec++;
    if (n_acc != DEPTH + 1 || cmd_ready_o !== 1'b0 || pending_o !== PW'(DEPTH)) begin
      n_err++;
      $display("FAIL fill: got accepted=%0d ready=%b pending=%0d, expected accepted=5 ready=0 pending=4",
               n_acc, cmd_ready_o, pending_o);
    end
    wait_in_wait(20, ok);
    stub_kick = 1'b1;
    take_rsp(20, ok, got, err);
    rose = 1'b0;
    for (int i = 0; i <= 2; i++) begin
      if (cmd_ready_o) begin rose = 1'b1; break; end
      @(negedge clock_i);
    end
    n_vec++;
    if (!rose) begin n_err++; $display("FAIL fill_ready_rise: got ready=%b, expected 1 within 2 cycles", cmd_ready_o); end
    for (int k = 0; k < DEPTH + 1; k++) begin
      if (k > 0) begin
        wait_in_wait(20, ok);
        stub_kick = 1'b1;
        take_rsp(20, ok, got, err);
      end
      n_vec++;
      if (!ok || sb.size() == 0) begin
        n_err++; $display("FAIL fill_rsp%0d: got no response, expected one", k);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_err++;
          $display("FAIL fill_rsp%0d: got res=%h rem=%h fct=%h, expected res=%h rem=%h fct=%h",
                   k, got.res, got.rem, got.fct, exp.res, exp.rem, exp.fct);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit acc, ok, stable, seen; rsp_t got, exp, snap; logic err; int s0;
    stub_mode = 0; stub_delay = 3; rsp_ready_i = 1'b0;
    push_cmd(8'hA1, 8'h0F, 2'b01, acc);
    push_cmd(8'h22, 8'h33, 2'b10, acc);
    push_cmd(8'hFF, 8'hFF, 2'b11, acc);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid_o) begin seen = 1'b1; break; end
      @(negedge clock_i);
    end
    snap = {rsp_res_o, rsp_rem_o, rsp_fct_o}; s0 = n_starts; stable = seen;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock_i);
      if ({rsp_res_o, rsp_rem_o, rsp_fct_o} !== snap || !rsp_valid_o) stable = 1'b0;
    end
    n_vec++;
    if (!stable) begin n_err++; $display("FAIL bp_hold: got res=%h rem=%h valid=%b, expected stable res=%h rem=%h", rsp_res_o, rsp_rem_o, rsp_valid_o, snap.res, snap.rem); end
    n_vec++;
    if (n_starts != s0 || pending_o !== PW'(2)) begin
      n_err++; $display("FAIL bp_no_start: got starts=%0d pending=%0d, expected starts=0 pending=2", n_starts - s0, pending_o);
    end
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      take_rsp(40, ok, got, err);
      n_vec++;
      if (!ok || sb.size() == 0) begin
        n_err++; $display("FAIL bp_rsp%0d: got no response, expected one", k);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_err++;
          $display("FAIL bp_rsp%0d: got res=%h rem=%h fct=%h, expected res=%h rem=%h fct=%h",
                   k, got.res, got.rem, got.fct, exp.res, exp.rem, exp.fct);
        end
      end
    end
  endtask

  task automatic test_sticky_done();
    bit acc, ok, quiet; rsp_t got, exp; logic err; int s0;
    stub_mode = 2; stub_delay = 6;
    for (int k = 0; k < 2; k++) begin
      s0 = n_starts;
      if (k == 0) push_cmd(8'h05, 8'h09, 2'b01, acc);
      else        push_cmd(8'h11, 8'h22, 2'b10, acc);
      if (k == 1) begin
        for (int i = 0; i < 10 && n_starts == s0; i++) @(negedge clock_i);
        quiet = (n_starts != s0);
        for (int i = 0; i < 5; i++) begin
          @(negedge clock_i);
          if (rsp_valid_o) quiet = 1'b0;
        end
        n_vec++;
        if (!quiet) begin n_err++; $display("FAIL sticky_wait: got early rsp_valid=%b, expected 0 while done held", rsp_valid_o); end
      end
      take_rsp(40, ok, got, err);
      n_vec++;
      if (!ok || sb.size() == 0) begin
        n_err++; $display("FAIL sticky_rsp%0d: got no response, expected one", k);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_err++;
          $display("FAIL sticky_rsp%0d: got res=%h rem=%h fct=%h, expected res=%h rem=%h fct=%h",
                   k, got.res, got.rem, got.fct, exp.res, exp.rem, exp.fct);
        end
      end
    end
    stub_mode = 0;
    repeat (2) @(negedge clock_i);
  endtask

  task automatic test_mid_reset();
    bit acc; int s0;
    stub_mode = 1;
    for (int i = 0; i < 4; i++) push_cmd(WIDTH'(8'h30 + i), WIDTH'(i), 2'(i), acc);
    repeat (2) @(negedge clock_i);
    reset_i = 1'b1;
    @(negedge clock_i);
    reset_i = 1'b0;
    sb.delete();
    n_vec++;
    if ({cmd_ready_o, calc_start_o, calc_a_o, calc_b_o, calc_fct_o, rsp_valid_o,
         rsp_res_o, rsp_rem_o, rsp_fct_o, pending_o, busy_o} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got %h, expected all zero",
               {cmd_ready_o, calc_start_o, calc_a_o, calc_b_o, calc_fct_o, rsp_valid_o,
                rsp_res_o, rsp_rem_o, rsp_fct_o, pending_o, busy_o});
    end
    s0 = n_starts;
    repeat (30) @(negedge clock_i);
    n_vec++;
    if (n_starts != s0 || cmd_ready_o !== 1'b1) begin
      n_err++; $display("FAIL mid_reset_idle: got starts=%0d ready=%b, expected starts=0 ready=1", n_starts - s0, cmd_ready_o);
    end
  endtask

`ifdef DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    bit acc, ok; rsp_t got, exp; logic err; int cyc;
    stub_mode = 1; stub_delay = 4; rsp_ready_i = 1'b1;
    push_cmd(8'h40, 8'h02, 2'b11, acc);
    sb[sb.size()-1].res = '0;
    sb[sb.size()-1].rem = '0;
    push_cmd(8'h0C, 8'h03, 2'b01, acc);
    for (int i = 0; i < 20 && !calc_start_o; i++) @(negedge clock_i);
    cyc = 0;
    while (!rsp_valid_o && cyc < 40) begin
      @(negedge clock_i);
      cyc++;
      if (cyc == 8) stub_mode = 0;
    end
    take_rsp(1, ok, got, err);
    n_vec++;
    if (!ok || cyc != TIMEOUT + 1 || err !== 1'b1 || sb.size() == 0) begin
      n_err++; $display("FAIL timeout_rsp: got valid=%b cycles_from_issue=%0d err=%b, expected 1 %0d 1", ok, cyc, err, TIMEOUT + 1);
    end else begin
      exp = sb.pop_front();
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL timeout_data: got res=%h rem=%h fct=%h, expected res=%h rem=%h fct=%h",
                          got.res, got.rem, got.fct, exp.res, exp.rem, exp.fct);
      end
    end
    take_rsp(40, ok, got, err);
    n_vec++;
    if (!ok || err !== 1'b0 || sb.size() == 0) begin
      n_err++; $display("FAIL timeout_next: got valid=%b err=%b, expected 1 0", ok, err);
    end else begin
      exp = sb.pop_front();
      if (got !== exp) begin
        n_err++; $display("FAIL timeout_next: got res=%h rem=%h fct=%h, expected res=%h rem=%h fct=%h",
                          got.res, got.rem, got.fct, exp.res, exp.rem, exp.fct);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_sticky_done();
    test_mid_reset();
`ifdef DISPATCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
